// File: rtl/halt_result_writer.sv
// halt_result_writer: after the core halts, dumps the captured result word as
// eight uppercase hex characters plus a pass/fail character into the display buffer.
module halt_result_writer #(
   parameter logic [5:0]  BASE_ADDR  = 6'd0,
   parameter logic [31:0] PASS_VALUE = 32'h00000315,
   parameter logic [7:0]  PASS_CHAR  = 8'h2B,
   parameter logic [7:0]  FAIL_CHAR  = 8'h2D
) (
   input  logic        i_clk,
   input  logic        i_srst_n,
   input  logic [5:0]  i_op_w,
   input  logic [31:0] i_result,
   input  logic        i_wr_ready,
   output logic        o_we,
   output logic [5:0]  o_write_addr,
   output logic [7:0]  o_write_data,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass
);

   localparam logic [5:0] HALT_OP  = 6'b111111;
   localparam logic [3:0] LAST_IDX = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      r_state, w_state_next;
   logic [3:0]  r_idx, w_idx_next;
   logic [31:0] r_word, w_word_next;
   logic        r_pass, w_pass_next;
   logic        r_halt_d;

   logic        w_halt;
   logic        w_trigger;
   logic        w_writing;
   logic [4:0]  w_nib_lsb;
   logic [3:0]  w_nibble;
   logic [7:0]  w_hex_char;
   logic [7:0]  w_char;

   // Halt is level-sensitive on the opcode; only its rising edge starts a dump.
   assign w_halt    = (i_op_w == HALT_OP);
   assign w_trigger = w_halt & ~r_halt_d;
   assign w_writing = (r_state == ST_WRITE);

   // Digit idx 0 is the most significant nibble.
   assign w_nib_lsb  = 5'd28 - {r_idx[2:0], 2'b00};
   assign w_nibble   = r_word[w_nib_lsb +: 4];
   assign w_hex_char = (w_nibble < 4'd10) ? (8'h30 + {4'b0000, w_nibble})
                                          : (8'h37 + {4'b0000, w_nibble});
   assign w_char     = (r_idx == LAST_IDX) ? (r_pass ? PASS_CHAR : FAIL_CHAR) : w_hex_char;

   // Outputs are decoded purely from registered state, so a stalled write holds steady.
   assign o_we         = w_writing;
   assign o_write_addr = w_writing ? (BASE_ADDR + {2'b00, r_idx}) : 6'd0;
   assign o_write_data = w_writing ? w_char : 8'd0;
   assign o_busy       = w_writing;
   assign o_done       = (r_state == ST_DONE);
   assign o_pass       = r_pass & o_done;

   // Next-state logic: capture on trigger, advance one character per accepted write.
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_word_next  = r_word;
      w_pass_next  = r_pass;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_trigger) begin
               w_word_next  = i_result;
               w_pass_next  = (i_result == PASS_VALUE);
               w_idx_next   = 4'd0;
               w_state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Triggers are deliberately ignored here; nothing is queued.
            if (i_wr_ready) begin
               if (r_idx == LAST_IDX) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_idx_next = r_idx + 4'd1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State and capture registers; halt_d resets high so a halt held through reset is not an edge.
   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= 4'd0;
         r_word   <= 32'd0;
         r_pass   <= 1'b0;
         r_halt_d <= 1'b1;
      end else begin
         r_state  <= w_state_next;
         r_idx    <= w_idx_next;
         r_word   <= w_word_next;
         r_pass   <= w_pass_next;
         r_halt_d <= w_halt;
      end
   end

endmodule
